// File: rtl/chip8_audio_pkg.sv
// chip8_audio_pkg
// Shared types and default constants for the Chip-8 audio blocks
// (sound-timer sequencer and the tick divider it shares with the delay timer).
package chip8_audio_pkg;

  // Codec sample width; samples are signed two's complement.
  localparam int SND_SAMPLE_W = 16;

  // Defaults for an 11.2896 MHz audio clock and a 44.1 kHz codec.
  localparam int unsigned                SND_TICK_DIV    = 188160;
  localparam int unsigned                SND_HALF_PERIOD = 22;
  localparam logic [SND_SAMPLE_W-1:0]    SND_AMPLITUDE   = 16'h2000;
  localparam logic [SND_SAMPLE_W-1:0]    SND_FADE_STEP   = 16'h0100;

  // Sequencer states; FADE is only reachable when the fade ramp is built.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FADE = 2'd2
  } snd_state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int snd_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip8_sound_ctrl_if.sv
// chip8_sound_ctrl_if
// CPU write port, codec sample request and the sequencer's status/sample
// outputs. The master side is the CPU/codec, the slave side is the sequencer.
interface chip8_sound_ctrl_if;
  import chip8_audio_pkg::*;

  logic                            st_we;
  logic [7:0]                      st_wdata;
  logic                            sample_req;
  logic signed [SND_SAMPLE_W-1:0]  audio_output;
  logic [7:0]                      st_value;
  logic                            active;

  modport master (
    output st_we, st_wdata, sample_req,
    input  audio_output, st_value, active
  );

  modport slave (
    input  st_we, st_wdata, sample_req,
    output audio_output, st_value, active
  );

endinterface

// File: rtl/chip8_tick_gen.sv
// chip8_tick_gen
// Free-running divider: tick_cnt counts 0..DIV-1 and wraps; tick is high for
// the single cycle in which tick_cnt sits at DIV-1.
module chip8_tick_gen
  import chip8_audio_pkg::*;
#(
  parameter int unsigned DIV = SND_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W = snd_cnt_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  // Divider counter, wraps at DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/chip8_sound_ctrl.sv
// chip8_sound_ctrl
// Chip-8 sound-timer sequencer: holds the CPU-written sound timer, counts it
// down at 60 Hz and emits a square-wave tone, one sample per codec request,
// while the timer is non-zero.
// Optional build macro CHIP8_SOUND_FADE_EN adds a FADE state that ramps the
// tone amplitude down at timer expiry instead of cutting it off.
module chip8_sound_ctrl
  import chip8_audio_pkg::*;
#(
  parameter int unsigned             TICK_DIV    = SND_TICK_DIV,
  parameter int unsigned             HALF_PERIOD = SND_HALF_PERIOD,
  parameter logic [SND_SAMPLE_W-1:0] AMPLITUDE   = SND_AMPLITUDE
`ifdef CHIP8_SOUND_FADE_EN
  ,
  parameter logic [SND_SAMPLE_W-1:0] FADE_STEP   = SND_FADE_STEP
`endif
) (
  input  logic               clk,
  input  logic               reset,
  chip8_sound_ctrl_if.slave  bus
);

  localparam int               PH_W     = snd_cnt_w(HALF_PERIOD);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam int               AMP_W    = SND_SAMPLE_W - 1;
  localparam logic [AMP_W-1:0] AMP_FULL = AMPLITUDE[AMP_W-1:0];

  logic                           tick;
  logic [7:0]                     st_value_p1;
  snd_state_t                     state;
  snd_state_t                     state_nxt;
  logic                           active_p1;
  logic signed [SND_SAMPLE_W-1:0] audio_p1;
  logic [AMP_W-1:0]               amp;
  logic [PH_W-1:0]                phase;
  logic                           polarity;  // 1 = positive half-cycle
  logic                           start_tone;

  // Magnitude plus polarity to a signed sample; the 15-bit magnitude is
  // widened to 16 bits before negation so -amp cannot overflow.
  function automatic logic signed [SND_SAMPLE_W-1:0] tone_sample(
    input logic [AMP_W-1:0] mag,
    input logic             pos
  );
    logic signed [SND_SAMPLE_W-1:0] m;
    m = signed'({1'b0, mag});
    return pos ? m : -m;
  endfunction

`ifdef CHIP8_SOUND_FADE_EN
  // One fade step, clamped at zero.
  function automatic logic [AMP_W-1:0] fade_amp(input logic [AMP_W-1:0] a);
    if ({1'b0, a} <= FADE_STEP) begin
      return '0;
    end
    return a - FADE_STEP[AMP_W-1:0];
  endfunction

  logic resume_tone;
  assign resume_tone = (state == FADE) && (state_nxt == PLAY);
`endif

  assign start_tone = (state == IDLE) && (state_nxt == PLAY);

  chip8_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Sound timer: a CPU write takes priority over a coincident tick decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_value_p1 <= 8'd0;
    end else if (bus.st_we) begin
      st_value_p1 <= bus.st_wdata;
    end else if (tick && (st_value_p1 != 8'd0)) begin
      st_value_p1 <= st_value_p1 - 8'd1;
    end
  end

  // Sequencer next state, driven by the registered timer value.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (st_value_p1 != 8'd0) begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (st_value_p1 == 8'd0) begin
`ifdef CHIP8_SOUND_FADE_EN
          state_nxt = FADE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef CHIP8_SOUND_FADE_EN
      FADE: begin
        if (st_value_p1 != 8'd0) begin
          state_nxt = PLAY;
        end else if (amp == '0) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register; active is registered alongside it so both move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      active_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      active_p1 <= (state_nxt != IDLE);
    end
  end

  // Tone generator: a request uses the state as registered now; tone-entry
  // loads override the per-sample updates taken in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_p1 <= '0;
      amp      <= '0;
      phase    <= '0;
      polarity <= 1'b1;
    end else begin
      if (bus.sample_req) begin
        if (state == IDLE) begin
          audio_p1 <= '0;
        end else begin
          audio_p1 <= tone_sample(amp, polarity);
          if (phase == PH_LAST) begin
            phase    <= '0;
            polarity <= ~polarity;
          end else begin
            phase <= phase + PH_W'(1);
          end
`ifdef CHIP8_SOUND_FADE_EN
          if (state == FADE) begin
            amp <= fade_amp(amp);
          end
`endif
        end
      end
      if (start_tone) begin
        amp      <= AMP_FULL;
        phase    <= '0;
        polarity <= 1'b1;
      end
`ifdef CHIP8_SOUND_FADE_EN
      if (resume_tone) begin
        amp <= AMP_FULL;
      end
`endif
    end
  end

  assign bus.audio_output = audio_p1;
  assign bus.st_value     = st_value_p1;
  assign bus.active       = active_p1;

endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// tb_chip8_sound_ctrl
// Directed bench for chip8_sound_ctrl with TICK_DIV=4, HALF_PERIOD=2,
// AMPLITUDE=0x2000 and (when CHIP8_SOUND_FADE_EN is defined) FADE_STEP=0x0800.
module tb_chip8_sound_ctrl;
  import chip8_audio_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_tick = 0;
  int held_bad;

  logic [15:0] exp_q[$];

  chip8_sound_ctrl_if bus();

  chip8_sound_ctrl #(
    .TICK_DIV    (4),
    .HALF_PERIOD (2),
    .AMPLITUDE   (16'h2000)
`ifdef CHIP8_SOUND_FADE_EN
    ,
    .FADE_STEP   (16'h0800)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [7:0] v);
    bus.st_we    = 1'b1;
    bus.st_wdata = v;
    step();
    bus.st_we    = 1'b0;
  endtask

  task automatic sample(input string tag, input logic [15:0] e);
    bus.sample_req = 1'b1;
    exp_q.push_back(e);
    step();
    bus.sample_req = 1'b0;
    check(tag, bus.audio_output, exp_q.pop_front());
  endtask

  task automatic wait_st(input string tag, input logic [7:0] v, input int bound);
    int k;
    k = 0;
    while ((bus.st_value !== v) && (k < bound)) begin
      step();
      k++;
    end
    check(tag, {8'h00, bus.st_value}, {8'h00, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.st_we      = 1'b0;
    bus.st_wdata   = 8'h00;
    bus.sample_req = 1'b0;

    // Reset state
    step();
    step();
    check("rst_audio", bus.audio_output, 16'h0000);
    check("rst_st", {8'h00, bus.st_value}, 16'h0000);
    check("rst_active", {15'h0, bus.active}, 16'h0000);
    reset = 1'b0;
    repeat (3) step();
    check("idle_st", {8'h00, bus.st_value}, 16'h0000);
    check("idle_active", {15'h0, bus.active}, 16'h0000);

    // Tone of 3 ticks
    wr(8'd3);
    check("wr3", {8'h00, bus.st_value}, 16'h0003);
    step();
    check("play_active", {15'h0, bus.active}, 16'h0001);
    sample("s0", 16'h2000);
    sample("s1", 16'h2000);
    sample("s2", 16'hE000);
    sample("s3", 16'hE000);
    wait_st("st_one", 8'd1, 12);
    repeat (3) step();
    check("st_hold", {8'h00, bus.st_value}, 16'h0001);
    step();
    check("st_expire", {8'h00, bus.st_value}, 16'h0000);
    t_tick = cyc;
    step();
`ifdef CHIP8_SOUND_FADE_EN
    check("fade_active", {15'h0, bus.active}, 16'h0001);
    sample("f0", 16'h2000);
    sample("f1", 16'h1800);
    sample("f2", 16'hF000);
    sample("f3", 16'hF800);
    sample("f4", 16'h0000);
    check("fade_done", {15'h0, bus.active}, 16'h0000);
`else
    check("end_active", {15'h0, bus.active}, 16'h0000);
    sample("end_sample", 16'h0000);
`endif

    // Write coincident with tick
    while (((cyc - t_tick) % 4) != 0) step();
    wr(8'd2);
    check("wr2", {8'h00, bus.st_value}, 16'h0002);
    step();
    step();
    check("wr2_hold", {8'h00, bus.st_value}, 16'h0002);
    wr(8'd5);
    check("wr_beats_tick", {8'h00, bus.st_value}, 16'h0005);
    repeat (4) step();
    check("tick_after_wr", {8'h00, bus.st_value}, 16'h0004);

`ifdef CHIP8_SOUND_FADE_EN
    // Rewrite during fade
    wait_st("st_zero2", 8'd0, 24);
    step();
    check("fade2_active", {15'h0, bus.active}, 16'h0001);
    sample("g0", 16'h2000);
    sample("g1", 16'h1800);
    wr(8'd4);
    step();
    check("resume_active", {15'h0, bus.active}, 16'h0001);
    sample("r0", 16'hE000);
    sample("r1", 16'hE000);
`endif

    // Long tone, then hold without requests
    wr(8'd255);
    step();
    step();
    check("long_active", {15'h0, bus.active}, 16'h0001);
    sample("h0", 16'h2000);
    held_bad = 0;
    for (int i = 0; i < 101; i++) begin
      step();
      if (bus.audio_output !== 16'sh2000) held_bad++;
    end
    check("hold_steady", held_bad[15:0], 16'h0000);
    check("hold_output", bus.audio_output, 16'h2000);
    sample("h1", 16'h2000);
    sample("h2", 16'hE000);

    // Asynchronous reset mid-tone
    #2;
    reset = 1'b1;
    #1;
    check("arst_audio", bus.audio_output, 16'h0000);
    check("arst_st", {8'h00, bus.st_value}, 16'h0000);
    check("arst_active", {15'h0, bus.active}, 16'h0000);
    step();
    reset = 1'b0;
    repeat (4) step();
    check("post_rst_st", {8'h00, bus.st_value}, 16'h0000);
    check("post_rst_active", {15'h0, bus.active}, 16'h0000);
    sample("post_rst_sample", 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
